lane_judge_engine: RTL and testbench

//  Parametrised note-field, hit-judgement and scoring engine for the music game; generalises the fixed
//  4-column x 16-row block/score path to LANES lanes x ROWS rows. Adds graded judgement (PERFECT/GOOD/MISS),

---
 rtl/lane_judge_engine.sv | 133 +++++++++++++
 tb/tb_lane_judge_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_judge_engine.sv
// rtl/lane_judge_engine.sv - note field, graded hit judgement and scoring for LANES x ROWS
// Hits are judged on the pre-shift field; a bit falling out of the bottom row counts as a miss.
module lane_judge_engine #(
  parameter int LANES    = 4,
  parameter int ROWS     = 16,
  parameter int HIT_ROW  = 14,
  parameter int GOOD_WIN = 1,
  parameter int PTS_PERF = 3,
  parameter int PTS_GOOD = 1,
  parameter int SCORE_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   run,
  input  logic                   clear,
  input  logic [LANES-1:0]       spawn,
  input  logic [LANES-1:0]       key,
  output logic [LANES*ROWS-1:0]  field,
  output logic [SCORE_W-1:0]     score,
  output logic [15:0]            combo,
  output logic [15:0]            max_combo,
  output logic [1:0]             judge,
  output logic                   judge_vld
);

  localparam int CNT_W = 6;
  localparam int ADD_W = SCORE_W + 1;

  logic [LANES*ROWS-1:0] field_q, field_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [15:0]           combo_q, combo_d;
  logic [15:0]           max_combo_q, max_combo_d;
  logic [1:0]            judge_q, judge_d;
  logic                  judge_vld_q, judge_vld_d;
  logic [LANES-1:0]      key_prev_q;

  logic [LANES-1:0]      rise;
  logic [ROWS-1:0]       lane_v;
  logic                  found_v;
  logic [CNT_W-1:0]      p_cnt, g_cnt, m_cnt, h_cnt;
  logic [ADD_W-1:0]      score_add, score_sum;
  logic [16:0]           combo_sum;

  assign rise = key & ~key_prev_q;

  always_comb begin
    field_d = field_q;
    p_cnt   = '0;
    g_cnt   = '0;
    m_cnt   = '0;
    lane_v  = '0;
    found_v = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_v  = field_q[l*ROWS +: ROWS];
      found_v = 1'b0;
      if (run && rise[l]) begin
        // Search outward from the hit row, lower (later) row before upper at each distance.
        for (int d = 0; d <= GOOD_WIN; d++) begin
          if (!found_v && lane_v[HIT_ROW+d]) begin
            found_v          = 1'b1;
            lane_v[HIT_ROW+d] = 1'b0;
            if (d == 0) p_cnt = p_cnt + CNT_W'(1);
            else        g_cnt = g_cnt + CNT_W'(1);
          end
          if (d != 0 && !found_v && lane_v[HIT_ROW-d]) begin
            found_v          = 1'b1;
            lane_v[HIT_ROW-d] = 1'b0;
            g_cnt            = g_cnt + CNT_W'(1);
          end
        end
      end
      if (run && tick) begin
        if (lane_v[ROWS-1]) m_cnt = m_cnt + CNT_W'(1);
        lane_v = {lane_v[ROWS-2:0], spawn[l]};
      end
      field_d[l*ROWS +: ROWS] = lane_v;
    end
  end

  always_comb begin
    h_cnt     = p_cnt + g_cnt;
    score_add = ADD_W'(p_cnt) * ADD_W'(PTS_PERF) + ADD_W'(g_cnt) * ADD_W'(PTS_GOOD);
    score_sum = {1'b0, score_q} + score_add;
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    combo_sum   = ((m_cnt != '0) ? 17'd0 : {1'b0, combo_q}) + 17'(h_cnt);
    combo_d     = combo_sum[16] ? 16'hFFFF : combo_sum[15:0];
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;

    judge_vld_d = (h_cnt != '0) || (m_cnt != '0);
    if (m_cnt != '0)      judge_d = 2'd3;
    else if (g_cnt != '0) judge_d = 2'd2;
    else if (p_cnt != '0) judge_d = 2'd1;
    else                  judge_d = judge_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_q     <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      judge_q     <= '0;
      judge_vld_q <= 1'b0;
      key_prev_q  <= '0;
    end else if (clear) begin
      field_q     <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      judge_q     <= '0;
      judge_vld_q <= 1'b0;
      key_prev_q  <= '0;
    end else begin
      field_q     <= field_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      judge_q     <= judge_d;
      judge_vld_q <= judge_vld_d;
      key_prev_q  <= key;
    end
  end

  assign field     = field_q;
  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_combo_q;
  assign judge     = judge_q;
  assign judge_vld = judge_vld_q;

endmodule

// File: tb/tb_lane_judge_engine.sv
// tb/tb_lane_judge_engine.sv - directed checks of lane_judge_engine with hand-computed expectations
module tb_lane_judge_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        run = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  spawn = '0;
  logic [3:0]  key = '0;
  logic [63:0] field;
  logic [31:0] score;
  logic [15:0] combo;
  logic [15:0] max_combo;
  logic [1:0]  judge;
  logic        judge_vld;

  int n_checks = 0;
  int n_pass   = 0;
  bit vld_seen;

  lane_judge_engine dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .run       (run),
    .clear     (clear),
    .spawn     (spawn),
    .key       (key),
    .field     (field),
    .score     (score),
    .combo     (combo),
    .max_combo (max_combo),
    .judge     (judge),
    .judge_vld (judge_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [3:0] s);
    tick  = 1'b1;
    spawn = s;
    cyc();
    tick  = 1'b0;
    spawn = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick(4'b0000);
  endtask

  task automatic press(input logic [3:0] m);
    key = m;
    cyc();
  endtask

  task automatic release_keys();
    key = '0;
    cyc();
  endtask

  function automatic logic [63:0] bitpos(input int l, input int r);
    logic [63:0] one;
    one = 64'd1;
    return one << (l*16 + r);
  endfunction

  initial begin
    cyc();
    cyc();
    check("rst_field", field, 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_combo", 64'(combo), 64'd0);
    check("rst_max", 64'(max_combo), 64'd0);
    check("rst_judge", 64'(judge), 64'd0);
    check("rst_vld", 64'(judge_vld), 64'd0);
    rst = 1'b0;
    cyc();

    // single PERFECT in lane 0
    do_tick(4'b0001);
    ticks(14);
    check("p_field_pre", field, bitpos(0, 14));
    press(4'b0001);
    check("p_score", 64'(score), 64'd3);
    check("p_combo", 64'(combo), 64'd1);
    check("p_max", 64'(max_combo), 64'd1);
    check("p_judge", 64'(judge), 64'd1);
    check("p_vld", 64'(judge_vld), 64'd1);
    check("p_field", field, 64'd0);
    cyc();
    check("p_held_vld", 64'(judge_vld), 64'd0);
    check("p_held_score", 64'(score), 64'd3);
    release_keys();

    // GOOD at row 15 in lane 1, miss out of lane 2
    do_tick(4'b0110);
    ticks(15);
    check("g_field_pre", field, bitpos(1, 15) | bitpos(2, 15));
    press(4'b0010);
    check("g_score", 64'(score), 64'd4);
    check("g_combo", 64'(combo), 64'd2);
    check("g_judge", 64'(judge), 64'd2);
    check("g_vld", 64'(judge_vld), 64'd1);
    check("g_field", field, bitpos(2, 15));
    key = '0;
    do_tick(4'b0000);
    check("m_combo", 64'(combo), 64'd0);
    check("m_judge", 64'(judge), 64'd3);
    check("m_vld", 64'(judge_vld), 64'd1);
    check("m_max", 64'(max_combo), 64'd2);
    check("m_score", 64'(score), 64'd4);
    check("m_field", field, 64'd0);

    // build combo 5, then two PERFECT plus one MISS in the same cycle
    do_tick(4'b1111);
    ticks(14);
    press(4'b1111);
    check("q_score", 64'(score), 64'd16);
    check("q_combo", 64'(combo), 64'd4);
    release_keys();
    do_tick(4'b1100);
    do_tick(4'b0011);
    ticks(13);
    check("s_field_a", field, bitpos(0,13) | bitpos(1,13) | bitpos(2,14) | bitpos(3,14));
    press(4'b0100);
    check("s_score_a", 64'(score), 64'd19);
    check("s_combo_a", 64'(combo), 64'd5);
    key = '0;
    do_tick(4'b0000);
    check("s_field_b", field, bitpos(0,14) | bitpos(1,14) | bitpos(3,15));
    key  = 4'b0011;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s_score", 64'(score), 64'd25);
    check("s_combo", 64'(combo), 64'd2);
    check("s_judge", 64'(judge), 64'd3);
    check("s_vld", 64'(judge_vld), 64'd1);
    check("s_max", 64'(max_combo), 64'd5);
    check("s_field", field, 64'd0);
    cyc();
    check("s_vld_once", 64'(judge_vld), 64'd0);
    release_keys();

    // pause with key held and ticks ignored
    do_tick(4'b0001);
    ticks(14);
    run = 1'b0;
    key = 4'b0001;
    vld_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick = (i % 10 == 0);
      cyc();
      if (judge_vld) vld_seen = 1'b1;
    end
    tick = 1'b0;
    check("pz_vld_seen", 64'(vld_seen), 64'd0);
    check("pz_field", field, bitpos(0, 14));
    check("pz_score", 64'(score), 64'd25);
    check("pz_combo", 64'(combo), 64'd2);
    run = 1'b1;
    cyc();
    check("rs_vld", 64'(judge_vld), 64'd0);
    check("rs_field", field, bitpos(0, 14));
    release_keys();
    press(4'b0001);
    check("rp_score", 64'(score), 64'd28);
    check("rp_combo", 64'(combo), 64'd3);
    check("rp_judge", 64'(judge), 64'd1);
    check("rp_vld", 64'(judge_vld), 64'd1);
    check("rp_field", field, 64'd0);
    release_keys();

    // empty press
    press(4'b0010);
    check("e_vld", 64'(judge_vld), 64'd0);
    check("e_combo", 64'(combo), 64'd3);
    check("e_judge", 64'(judge), 64'd1);
    check("e_score", 64'(score), 64'd28);
    release_keys();

    // rows 14 and 13 occupied: row 14 taken first, then row 13 is GOOD
    do_tick(4'b0001);
    do_tick(4'b0001);
    ticks(13);
    check("w_field_pre", field, bitpos(0,14) | bitpos(0,13));
    press(4'b0001);
    check("w_score_a", 64'(score), 64'd31);
    check("w_judge_a", 64'(judge), 64'd1);
    check("w_field_a", field, bitpos(0, 13));
    release_keys();
    press(4'b0001);
    check("w_score_b", 64'(score), 64'd32);
    check("w_combo_b", 64'(combo), 64'd5);
    check("w_judge_b", 64'(judge), 64'd2);
    check("w_field_b", field, 64'd0);
    release_keys();

    // synchronous clear
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("c_score", 64'(score), 64'd0);
    check("c_combo", 64'(combo), 64'd0);
    check("c_max", 64'(max_combo), 64'd0);
    check("c_judge", 64'(judge), 64'd0);

    // combo saturation from a preloaded all-ones value
    do_tick(4'b0001);
    ticks(14);
    force dut.combo_q = 16'hFFFF;
    #1;
    release dut.combo_q;
    press(4'b0001);
    check("sat_combo", 64'(combo), 64'hFFFF);
    check("sat_max", 64'(max_combo), 64'hFFFF);
    check("sat_score", 64'(score), 64'd3);
    check("sat_vld", 64'(judge_vld), 64'd1);

    // asynchronous reset mid-cycle
    do_tick(4'b1010);
    #2;
    rst = 1'b1;
    #1;
    check("ar_field", field, 64'd0);
    check("ar_score", 64'(score), 64'd0);
    check("ar_combo", 64'(combo), 64'd0);
    check("ar_max", 64'(max_combo), 64'd0);
    check("ar_judge", 64'(judge), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
